// File: rtl/ultrascan_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ultrascan_pkg
//  Description : Shared definitions for the automata stream controller:
//                symbol width and the controller FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ultrascan_pkg;

    // Width of one input symbol fed to the automata kernel.
    localparam int SYMBOL_W = 8;

    // Explicit 3-bit state codes; the enum below is built on these values so
    // that any legacy code comparing against raw codes keeps working.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        CTRL_IDLE  = ST_IDLE,
        CTRL_INIT  = ST_INIT,
        CTRL_RUN   = ST_RUN,
        CTRL_DRAIN = ST_DRAIN,
        CTRL_DONE  = ST_DONE
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/report_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : report_fifo
//  Description : First-word-fall-through FIFO holding kernel report entries.
//                pop_data shows the head entry whenever the FIFO is non-empty
//                and reads as zero when empty. A push and a pop in the same
//                cycle on a full FIFO are both honoured.
//  Ports       : clk, reset (sync, active-low), push/push_data (write side),
//                pop/pop_data (read side), empty, count (occupancy).
//  Revision    : 1.0 - initial release
// ============================================================================
module report_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   FILL_ONE = 1;
    localparam logic [PTR_W:0]   FULL_LVL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (fill == '0);
    assign full    = (fill == FULL_LVL);
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = fill;

    // Zeroed when empty so the report outputs read clean after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/automata_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : automata_stream_ctrl
//  Description : Streams symbols into an automata kernel and queues the
//                kernel's non-zero report vectors, tagged with the offset of
//                the symbol that produced them, into a report FIFO.
//                FSM: IDLE -> INIT (kernel reset) -> RUN -> DRAIN -> DONE.
//  Ports       : clk, reset (sync, active-low)
//                start/stream_len        - begin a stream of stream_len symbols
//                s_valid/s_ready/s_data  - symbol input stream
//                k_symbols/k_run/k_reset - kernel drive
//                k_report                - kernel report outputs
//                r_valid/r_ready/r_vector/r_offset - report entry stream
//                busy, done              - status
//                report_count            - pushes this stream (optional)
//  Options     : ULTRASCAN_REPORT_COUNT_EN adds the report_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module automata_stream_ctrl
    import ultrascan_pkg::*;
#(
    parameter int NUM_REPORTS = 1,
    parameter int OFFSET_W    = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int INIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [OFFSET_W-1:0]    stream_len,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [SYMBOL_W-1:0]    s_data,
    output logic [SYMBOL_W-1:0]    k_symbols,
    output logic                   k_run,
    output logic                   k_reset,
    input  logic [NUM_REPORTS-1:0] k_report,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [NUM_REPORTS-1:0] r_vector,
    output logic [OFFSET_W-1:0]    r_offset,
    output logic                   busy,
    output logic                   done
`ifdef ULTRASCAN_REPORT_COUNT_EN
    ,
    output logic [OFFSET_W-1:0]    report_count
`endif
);

    localparam int                  CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                  ENTRY_W   = NUM_REPORTS + OFFSET_W;
    localparam int                  INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0]   INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [INIT_W-1:0]   INIT_ONE  = 1;
    localparam logic [OFFSET_W-1:0] OFF_ONE   = 1;
    localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(FIFO_DEPTH);

    ctrl_state_t          state;
    ctrl_state_t          state_nxt;
    logic [OFFSET_W-1:0]  remaining;
    logic [OFFSET_W-1:0]  offset;
    logic [INIT_W-1:0]    init_cnt;

    // Report pipeline: stage 1 is the k_run cycle, stage 2 the sample cycle.
    logic [OFFSET_W-1:0]  off_s1;
    logic [OFFSET_W-1:0]  off_s2;
    logic                 s2_valid;

    logic                 accept;
    logic                 start_ok;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     free_cnt;
    logic [1:0]           inflight_sum;
    logic [CNT_W-1:0]     inflight;
    logic [ENTRY_W-1:0]   fifo_out;

    assign inflight_sum = {1'b0, k_run} + {1'b0, s2_valid};
    assign inflight     = {{(CNT_W-2){1'b0}}, inflight_sum};
    assign free_cnt     = DEPTH_C - fifo_count;

    // Every accepted symbol may produce a report two cycles later, so a beat
    // is only taken when a FIFO slot is reserved for it on top of the beats
    // already in flight.
    assign s_ready  = (state == CTRL_RUN) && (remaining != '0) && (free_cnt > inflight);
    assign accept   = s_valid && s_ready;
    assign start_ok = (state == CTRL_IDLE) && start;

    assign k_reset = (state == CTRL_IDLE) || (state == CTRL_INIT);
    assign busy    = (state != CTRL_IDLE);
    assign done    = (state == CTRL_DONE);

    assign push = s2_valid && (k_report != '0);
    assign pop  = r_valid && r_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            CTRL_IDLE: begin
                if (start) begin
                    state_nxt = (stream_len == '0) ? CTRL_DONE : CTRL_INIT;
                end
            end
            CTRL_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt = CTRL_RUN;
                end
            end
            CTRL_RUN: begin
                if (accept && (remaining == OFF_ONE)) begin
                    state_nxt = CTRL_DRAIN;
                end
            end
            CTRL_DRAIN: begin
                // Stage 2 is sampled this very cycle, so only a beat still in
                // stage 1 keeps the drain open.
                if (!k_run) begin
                    state_nxt = CTRL_DONE;
                end
            end
            CTRL_DONE: begin
                state_nxt = CTRL_IDLE;
            end
            default: begin
                state_nxt = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= CTRL_IDLE;
            remaining <= '0;
            offset    <= '0;
            init_cnt  <= '0;
            k_symbols <= '0;
            k_run     <= 1'b0;
            off_s1    <= '0;
            off_s2    <= '0;
            s2_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            k_run    <= accept;
            s2_valid <= k_run;
            off_s2   <= off_s1;

            if (start_ok) begin
                remaining <= stream_len;
                offset    <= '0;
                init_cnt  <= '0;
            end else if (state == CTRL_INIT) begin
                init_cnt <= init_cnt + INIT_ONE;
            end

            if (accept) begin
                k_symbols <= s_data;
                off_s1    <= offset;
                offset    <= offset + OFF_ONE;
                remaining <= remaining - OFF_ONE;
            end
        end
    end

    report_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({k_report, off_s2}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign r_valid  = !fifo_empty;
    assign r_vector = fifo_out[ENTRY_W-1:OFFSET_W];
    assign r_offset = fifo_out[OFFSET_W-1:0];

`ifdef ULTRASCAN_REPORT_COUNT_EN
    logic [OFFSET_W-1:0] push_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            push_cnt <= '0;
        end else if (start_ok) begin
            push_cnt <= '0;
        end else if (push && (push_cnt != '1)) begin
            push_cnt <= push_cnt + OFF_ONE;
        end
    end

    assign report_count = push_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_automata_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_automata_stream_ctrl
//  Description : Directed self-checking bench for automata_stream_ctrl with a
//                small behavioural kernel that reports on selected symbols.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_automata_stream_ctrl;

    localparam int OFFSET_W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [OFFSET_W-1:0] stream_len;
    logic                s_valid;
    logic                s_ready;
    logic [7:0]          s_data;
    logic [7:0]          k_symbols;
    logic                k_run;
    logic                k_reset;
    logic [0:0]          k_report;
    logic                r_valid;
    logic                r_ready;
    logic [0:0]          r_vector;
    logic [OFFSET_W-1:0] r_offset;
    logic                busy;
    logic                done;
`ifdef ULTRASCAN_REPORT_COUNT_EN
    logic [OFFSET_W-1:0] report_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    automata_stream_ctrl #(
        .NUM_REPORTS (1),
        .OFFSET_W    (OFFSET_W),
        .FIFO_DEPTH  (4),
        .INIT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stream_len (stream_len),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .k_symbols  (k_symbols),
        .k_run      (k_run),
        .k_reset    (k_reset),
        .k_report   (k_report),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_vector   (r_vector),
        .r_offset   (r_offset),
        .busy       (busy),
        .done       (done)
`ifdef ULTRASCAN_REPORT_COUNT_EN
        ,
        .report_count (report_count)
`endif
    );

    // Behavioural kernel: the symbol clocked in under k_run shows up as a
    // report one cycle later if it matches.
    logic       kern_hit  = 1'b0;
    logic       match_en  = 1'b0;
    logic       match_all = 1'b0;
    logic [7:0] match_sym = 8'h00;

    always @(posedge clk) begin
        kern_hit <= k_run && match_en && (match_all || (k_symbols == match_sym));
    end
    assign k_report = kern_hit;

    // Mid-cycle monitor with running totals; tests work on differences.
    int cyc = 0, acc_total = 0, krun_total = 0, done_total = 0;
    int last_acc_cyc = 0, last_done_cyc = 0, krst_busy_total = 0;
    int rvalid_total = 0, pop_total = 0;
    int pop_off [64];
    logic pop_vec [64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (s_valid && s_ready) begin
            acc_total    <= acc_total + 1;
            last_acc_cyc <= cyc;
        end
        if (k_run) krun_total <= krun_total + 1;
        if (done) begin
            done_total    <= done_total + 1;
            last_done_cyc <= cyc;
        end
        if (busy && k_reset) krst_busy_total <= krst_busy_total + 1;
        if (r_valid) rvalid_total <= rvalid_total + 1;
        if (r_valid && r_ready) begin
            pop_off[pop_total % 64] <= int'(r_offset);
            pop_vec[pop_total % 64] <= r_vector[0];
            pop_total <= pop_total + 1;
        end
    end

    logic [7:0] sym_tab [16];
    int         sent;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [OFFSET_W-1:0] len);
        start      = 1'b1;
        stream_len = len;
        sent       = 0;
        tick();
        start      = 1'b0;
    endtask

    // Offers symbols every cycle; poke >= 0 issues a stray start on that cycle.
    task automatic feed(input int max_cycles, input int stop_acc, input int poke,
                        output logic saw_done);
        saw_done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            s_valid    = 1'b1;
            s_data     = sym_tab[sent % 16];
            start      = (i == poke);
            stream_len = 2;
            if (s_ready) sent++;
            tick();
            start = 1'b0;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (stop_acc > 0 && sent >= stop_acc) break;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stream_len = '0; s_valid = 1'b0;
        s_data = 8'h00; r_ready = 1'b0;
        repeat (3) tick();
        total++; if (s_ready !== 1'b0)   $display("FAIL rst_s_ready got %b want 0", s_ready);     else passed++;
        total++; if (k_symbols !== 8'h0) $display("FAIL rst_k_symbols got %h want 00", k_symbols); else passed++;
        total++; if (k_run !== 1'b0)     $display("FAIL rst_k_run got %b want 0", k_run);         else passed++;
        total++; if (k_reset !== 1'b1)   $display("FAIL rst_k_reset got %b want 1", k_reset);     else passed++;
        total++; if (r_valid !== 1'b0)   $display("FAIL rst_r_valid got %b want 0", r_valid);     else passed++;
        total++; if (r_vector !== 1'b0)  $display("FAIL rst_r_vector got %b want 0", r_vector);   else passed++;
        total++; if (r_offset !== '0)    $display("FAIL rst_r_offset got %0d want 0", r_offset);  else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL rst_busy got %b want 0", busy);           else passed++;
        total++; if (done !== 1'b0)      $display("FAIL rst_done got %b want 0", done);           else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_stream();
        logic seen;
        int b_krst, b_krun, b_acc, b_rv, b_done;
        for (int i = 0; i < 16; i++) sym_tab[i] = 8'(8'h40 + i);
        match_en = 1'b0; r_ready = 1'b1;
        b_krst = krst_busy_total; b_krun = krun_total; b_acc = acc_total;
        b_rv = rvalid_total; b_done = done_total;
        start_stream(5);
        feed(100, 0, 6, seen);
        repeat (3) tick();
        total++; if (seen !== 1'b1) $display("FAIL basic_done_seen got %b want 1", seen); else passed++;
        total++; if (krst_busy_total - b_krst != 4) $display("FAIL basic_init_cycles got %0d want 4", krst_busy_total - b_krst); else passed++;
        total++; if (krun_total - b_krun != 5) $display("FAIL basic_k_run_pulses got %0d want 5", krun_total - b_krun); else passed++;
        total++; if (acc_total - b_acc != 5) $display("FAIL basic_accepts got %0d want 5", acc_total - b_acc); else passed++;
        total++; if (last_done_cyc - last_acc_cyc != 3) $display("FAIL basic_done_latency got %0d want 3", last_done_cyc - last_acc_cyc); else passed++;
        total++; if (done_total - b_done != 1) $display("FAIL basic_done_pulses got %0d want 1", done_total - b_done); else passed++;
        total++; if (rvalid_total - b_rv != 0) $display("FAIL basic_r_valid_cycles got %0d want 0", rvalid_total - b_rv); else passed++;
        total++; if (k_symbols !== 8'h44) $display("FAIL basic_k_symbols_hold got %h want 44", k_symbols); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else passed++;
    endtask

    task automatic test_single_report();
        logic seen;
        int b_pop;
        sym_tab[0] = 8'h26; sym_tab[1] = 8'h52; sym_tab[2] = 8'h30;
        match_en = 1'b1; match_all = 1'b0; match_sym = 8'h52; r_ready = 1'b1;
        b_pop = pop_total;
        start_stream(3);
        feed(100, 0, -1, seen);
        repeat (3) tick();
        total++; if (seen !== 1'b1) $display("FAIL single_done_seen got %b want 1", seen); else passed++;
        total++; if (pop_total - b_pop != 1) $display("FAIL single_entries got %0d want 1", pop_total - b_pop); else passed++;
        total++; if (pop_vec[b_pop % 64] !== 1'b1) $display("FAIL single_vector got %b want 1", pop_vec[b_pop % 64]); else passed++;
        total++; if (pop_off[b_pop % 64] != 1) $display("FAIL single_offset got %0d want 1", pop_off[b_pop % 64]); else passed++;
        total++; if (k_symbols !== 8'h30) $display("FAIL single_k_symbols got %h want 30", k_symbols); else passed++;
    endtask

    task automatic test_backpressure();
        logic seen;
        int b_acc, b_pop, b_done;
        match_en = 1'b1; match_all = 1'b1; r_ready = 1'b0;
        b_acc = acc_total; b_pop = pop_total; b_done = done_total;
        start_stream(10);
        feed(40, 0, -1, seen);
        total++; if (seen !== 1'b0) $display("FAIL bp_premature_done got %b want 0", seen); else passed++;
        total++; if (acc_total - b_acc != 4) $display("FAIL bp_queued got %0d want 4", acc_total - b_acc); else passed++;
        total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready got %b want 0", s_ready); else passed++;
        total++; if (r_valid !== 1'b1) $display("FAIL bp_r_valid got %b want 1", r_valid); else passed++;
        total++; if (r_offset !== '0) $display("FAIL bp_head_offset got %0d want 0", r_offset); else passed++;
        total++; if (k_run !== 1'b0) $display("FAIL bp_k_run_stalled got %b want 0", k_run); else passed++;
        r_ready = 1'b1;
        feed(300, 0, -1, seen);
        repeat (3) tick();
        total++; if (seen !== 1'b1) $display("FAIL bp_done_seen got %b want 1", seen); else passed++;
        total++; if (pop_total - b_pop != 10) $display("FAIL bp_entries got %0d want 10", pop_total - b_pop); else passed++;
        total++; if (done_total - b_done != 1) $display("FAIL bp_done_pulses got %0d want 1", done_total - b_done); else passed++;
        for (int k = 0; k < 10; k++) begin
            total++;
            if (pop_off[(b_pop + k) % 64] != k)
                $display("FAIL bp_offset_%0d got %0d want %0d", k, pop_off[(b_pop + k) % 64], k);
            else passed++;
        end
    endtask

    task automatic test_zero_len();
        int b_krun;
        r_ready = 1'b1;
        b_krun = krun_total;
        start_stream(0);
        total++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL zero_busy got %b want 1", busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL zero_done_clear got %b want 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL zero_busy_clear got %b want 0", busy); else passed++;
        tick();
        total++; if (krun_total - b_krun != 0) $display("FAIL zero_k_run got %0d want 0", krun_total - b_krun); else passed++;
    endtask

    task automatic test_reset_abort();
        logic seen;
        int b_done;
        match_en = 1'b1; match_all = 1'b1; r_ready = 1'b0;
        b_done = done_total;
        start_stream(10);
        feed(100, 3, -1, seen);
        total++; if (r_valid !== 1'b1) $display("FAIL abort_pre_r_valid got %b want 1", r_valid); else passed++;
        reset = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (k_reset !== 1'b1) $display("FAIL abort_k_reset got %b want 1", k_reset); else passed++;
        total++; if (r_valid !== 1'b0) $display("FAIL abort_r_valid got %b want 0", r_valid); else passed++;
        total++; if (k_run !== 1'b0) $display("FAIL abort_k_run got %b want 0", k_run); else passed++;
        reset = 1'b1;
        repeat (6) tick();
        total++; if (done_total - b_done != 0) $display("FAIL abort_done_pulses got %0d want 0", done_total - b_done); else passed++;
        total++; if (r_valid !== 1'b0) $display("FAIL abort_late_r_valid got %b want 0", r_valid); else passed++;
        r_ready = 1'b1;
    endtask

`ifdef ULTRASCAN_REPORT_COUNT_EN
    task automatic test_report_count();
        logic seen;
        match_en = 1'b1; match_all = 1'b1; r_ready = 1'b1;
        start_stream(7);
        feed(200, 0, -1, seen);
        tick();
        total++; if (report_count !== 32'd7) $display("FAIL rc_count got %0d want 7", report_count); else passed++;
        start_stream(0);
        total++; if (report_count !== 32'd0) $display("FAIL rc_cleared got %0d want 0", report_count); else passed++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_stream();
        test_single_report();
        test_backpressure();
        test_zero_len();
        test_reset_abort();
`ifdef ULTRASCAN_REPORT_COUNT_EN
        test_report_count();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
